// File: rtl/mips_multicycle_controller_if.sv
// +--------------------------------------------------------------------+
// | mips_multicycle_controller_if                                      |
// | Control bundle between the multicycle controller and its datapath. |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

interface mips_multicycle_controller_if;
  logic [5:0] opcode;
  logic [5:0] funccode;
  logic       zero;
  logic       mem_ready;
  logic       iord;
  logic       memread;
  logic       memwrite;
  logic       irwrite;
  logic       pcwrite;
  logic [1:0] pcsrc;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [2:0] aluoperation;
  logic       regwrite;
  logic [1:0] regdst;
  logic [1:0] memtoreg;
  logic       instr_done;
  logic       illegal;

  modport master (
    input  opcode, funccode, zero, mem_ready,
    output iord, memread, memwrite, irwrite, pcwrite, pcsrc, alusrca,
           alusrcb, aluoperation, regwrite, regdst, memtoreg, instr_done,
           illegal
  );

  modport slave (
    output opcode, funccode, zero, mem_ready,
    input  iord, memread, memwrite, irwrite, pcwrite, pcsrc, alusrca,
           alusrcb, aluoperation, regwrite, regdst, memtoreg, instr_done,
           illegal
  );
endinterface

`default_nettype wire

// File: rtl/mips_multicycle_controller.sv
// +--------------------------------------------------------------------+
// | mips_multicycle_controller                                         |
// | Moore FSM sequencing a shared-memory multicycle MIPS datapath.     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module mips_multicycle_controller (
  input  wire                           clk,
  input  wire                           rst,
  mips_multicycle_controller_if.master  bus
);

  localparam logic [5:0] c_OP_RTYPE = 6'b000000;
  localparam logic [5:0] c_OP_ADDI  = 6'b001000;
  localparam logic [5:0] c_OP_ANDI  = 6'b001100;
  localparam logic [5:0] c_OP_LW    = 6'b100011;
  localparam logic [5:0] c_OP_SW    = 6'b101011;
  localparam logic [5:0] c_OP_BEQ   = 6'b000100;
  localparam logic [5:0] c_OP_BNE   = 6'b000101;
  localparam logic [5:0] c_OP_J     = 6'b000010;
  localparam logic [5:0] c_OP_JR    = 6'b100000;
  localparam logic [5:0] c_OP_JAL   = 6'b000011;

  localparam logic [2:0] c_ALU_AND = 3'b000;
  localparam logic [2:0] c_ALU_OR  = 3'b001;
  localparam logic [2:0] c_ALU_ADD = 3'b010;
  localparam logic [2:0] c_ALU_SUB = 3'b011;
  localparam logic [2:0] c_ALU_SLT = 3'b100;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_R_WB, S_EXEC_I, S_I_WB,
    S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP, S_JR, S_JAL
  } state_t;

  state_t state_q;
  state_t state_d;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d          = state_q;
    bus.iord         = 1'b0;
    bus.memread      = 1'b0;
    bus.memwrite     = 1'b0;
    bus.irwrite      = 1'b0;
    bus.pcwrite      = 1'b0;
    bus.pcsrc        = 2'b00;
    bus.alusrca      = 1'b0;
    bus.alusrcb      = 2'b00;
    bus.aluoperation = 3'b000;
    bus.regwrite     = 1'b0;
    bus.regdst       = 2'b00;
    bus.memtoreg     = 2'b00;
    bus.instr_done   = 1'b0;
    bus.illegal      = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_FETCH;

      // PC+4 is written back only on the cycle the instruction word arrives.
      S_FETCH: begin
        bus.memread = 1'b1;
        if (bus.mem_ready) begin
          bus.irwrite      = 1'b1;
          bus.pcwrite      = 1'b1;
          bus.alusrcb      = 2'b01;
          bus.aluoperation = c_ALU_ADD;
          state_d          = S_DECODE;
        end
      end

      S_DECODE: begin
        bus.alusrcb      = 2'b11;
        bus.aluoperation = c_ALU_ADD;
        case (bus.opcode)
          c_OP_RTYPE:          state_d = S_EXEC_R;
          c_OP_ADDI, c_OP_ANDI: state_d = S_EXEC_I;
          c_OP_LW, c_OP_SW:    state_d = S_MEM_ADDR;
          c_OP_BEQ, c_OP_BNE:  state_d = S_BRANCH;
          c_OP_J:              state_d = S_JUMP;
          c_OP_JR:             state_d = S_JR;
          c_OP_JAL:            state_d = S_JAL;
          default: begin
            bus.illegal    = 1'b1;
            bus.instr_done = 1'b1;
            state_d        = S_FETCH;
          end
        endcase
      end

      S_EXEC_R: begin
        bus.alusrca = 1'b1;
        case (bus.funccode)
          6'b100100: bus.aluoperation = c_ALU_AND;
          6'b100101: bus.aluoperation = c_ALU_OR;
          6'b100010: bus.aluoperation = c_ALU_SUB;
          6'b101010: bus.aluoperation = c_ALU_SLT;
          default:   bus.aluoperation = c_ALU_ADD;
        endcase
        state_d = S_R_WB;
      end

      S_R_WB: begin
        bus.regwrite   = 1'b1;
        bus.regdst     = 2'b01;
        bus.instr_done = 1'b1;
        state_d        = S_FETCH;
      end

      S_EXEC_I: begin
        bus.alusrca      = 1'b1;
        bus.alusrcb      = 2'b10;
        bus.aluoperation = (bus.opcode == c_OP_ANDI) ? c_ALU_AND : c_ALU_ADD;
        state_d          = S_I_WB;
      end

      S_I_WB: begin
        bus.regwrite   = 1'b1;
        bus.instr_done = 1'b1;
        state_d        = S_FETCH;
      end

      S_MEM_ADDR: begin
        bus.alusrca      = 1'b1;
        bus.alusrcb      = 2'b10;
        bus.aluoperation = c_ALU_ADD;
        state_d          = (bus.opcode == c_OP_SW) ? S_MEM_WR : S_MEM_RD;
      end

      S_MEM_RD: begin
        bus.iord    = 1'b1;
        bus.memread = 1'b1;
        if (bus.mem_ready) state_d = S_MEM_WB;
      end

      S_MEM_WB: begin
        bus.regwrite   = 1'b1;
        bus.memtoreg   = 2'b01;
        bus.instr_done = 1'b1;
        state_d        = S_FETCH;
      end

      S_MEM_WR: begin
        bus.iord     = 1'b1;
        bus.memwrite = 1'b1;
        if (bus.mem_ready) begin
          bus.instr_done = 1'b1;
          state_d        = S_FETCH;
        end
      end

      S_BRANCH: begin
        bus.alusrca      = 1'b1;
        bus.aluoperation = c_ALU_SUB;
        bus.pcsrc        = 2'b01;
        bus.pcwrite      = (bus.opcode == c_OP_BNE) ? ~bus.zero : bus.zero;
        bus.instr_done   = 1'b1;
        state_d          = S_FETCH;
      end

      S_JUMP: begin
        bus.pcsrc      = 2'b10;
        bus.pcwrite    = 1'b1;
        bus.instr_done = 1'b1;
        state_d        = S_FETCH;
      end

      S_JR: begin
        bus.pcsrc      = 2'b11;
        bus.pcwrite    = 1'b1;
        bus.instr_done = 1'b1;
        state_d        = S_FETCH;
      end

      // PC already holds the return address, so r31 and PC commit together.
      S_JAL: begin
        bus.pcsrc      = 2'b10;
        bus.pcwrite    = 1'b1;
        bus.regwrite   = 1'b1;
        bus.regdst     = 2'b10;
        bus.memtoreg   = 2'b10;
        bus.instr_done = 1'b1;
        state_d        = S_FETCH;
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_mips_multicycle_controller.sv
// +--------------------------------------------------------------------+
// | tb_mips_multicycle_controller                                      |
// | Self-checking bench: directed vectors plus a random instruction    |
// | stream compared cycle by cycle against an instruction-level model. |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_mips_multicycle_controller;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mips_multicycle_controller_if bus ();

  mips_multicycle_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       pcwrite;
    logic [1:0] pcsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [2:0] aluop;
    logic       regwrite;
    logic [1:0] regdst;
    logic [1:0] memtoreg;
    logic       done;
    logic       illegal;
  } out_t;

  typedef struct {
    logic mr;
    out_t exp;
  } cyc_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    int         fw;
    int         mw;
    int         cyc;
    int         pcw;
    int         rw;
    int         mrd;
    int         mwr;
    int         ill;
  } vec_t;

  cyc_t q[$];
  vec_t vecs[13];

  function automatic out_t get_out();
    out_t o;
    o.iord     = bus.iord;
    o.memread  = bus.memread;
    o.memwrite = bus.memwrite;
    o.irwrite  = bus.irwrite;
    o.pcwrite  = bus.pcwrite;
    o.pcsrc    = bus.pcsrc;
    o.alusrca  = bus.alusrca;
    o.alusrcb  = bus.alusrcb;
    o.aluop    = bus.aluoperation;
    o.regwrite = bus.regwrite;
    o.regdst   = bus.regdst;
    o.memtoreg = bus.memtoreg;
    o.done     = bus.instr_done;
    o.illegal  = bus.illegal;
    return o;
  endfunction

  function automatic bit is_legal(logic [5:0] op);
    return op inside {6'h00, 6'h08, 6'h0c, 6'h23, 6'h2b, 6'h04, 6'h05,
                      6'h02, 6'h20, 6'h03};
  endfunction

  function automatic logic [2:0] r_alu(logic [5:0] fn);
    case (fn)
      6'h24:   return 3'b000;
      6'h25:   return 3'b001;
      6'h22:   return 3'b011;
      6'h2a:   return 3'b100;
      default: return 3'b010;
    endcase
  endfunction

  task automatic push(logic mr, out_t o);
    cyc_t c;
    c.mr  = mr;
    c.exp = o;
    q.push_back(c);
  endtask

  // Instruction-level reference: expected per-cycle outputs of one instruction.
  task automatic model_instr(logic [5:0] op, logic [5:0] fn, logic z, int fw, int mw);
    out_t o;
    for (int i = 0; i < fw; i++) begin
      o = '0; o.memread = 1'b1; push(1'b0, o);
    end
    o = '0; o.memread = 1'b1; o.irwrite = 1'b1; o.pcwrite = 1'b1;
    o.alusrcb = 2'b01; o.aluop = 3'b010; push(1'b1, o);
    o = '0; o.alusrcb = 2'b11; o.aluop = 3'b010;
    if (!is_legal(op)) begin
      o.illegal = 1'b1; o.done = 1'b1; push(1'($urandom), o);
      return;
    end
    push(1'($urandom), o);
    o = '0;
    if (op == 6'h00) begin
      o.alusrca = 1'b1; o.aluop = r_alu(fn); push(1'($urandom), o);
      o = '0; o.regwrite = 1'b1; o.regdst = 2'b01; o.done = 1'b1; push(1'($urandom), o);
    end else if (op == 6'h08 || op == 6'h0c) begin
      o.alusrca = 1'b1; o.alusrcb = 2'b10; o.aluop = (op == 6'h08) ? 3'b010 : 3'b000;
      push(1'($urandom), o);
      o = '0; o.regwrite = 1'b1; o.done = 1'b1; push(1'($urandom), o);
    end else if (op == 6'h23 || op == 6'h2b) begin
      o.alusrca = 1'b1; o.alusrcb = 2'b10; o.aluop = 3'b010; push(1'($urandom), o);
      o = '0; o.iord = 1'b1;
      if (op == 6'h23) o.memread = 1'b1; else o.memwrite = 1'b1;
      for (int i = 0; i < mw; i++) push(1'b0, o);
      if (op == 6'h2b) o.done = 1'b1;
      push(1'b1, o);
      if (op == 6'h23) begin
        o = '0; o.regwrite = 1'b1; o.memtoreg = 2'b01; o.done = 1'b1; push(1'($urandom), o);
      end
    end else if (op == 6'h04 || op == 6'h05) begin
      o.alusrca = 1'b1; o.aluop = 3'b011; o.pcsrc = 2'b01; o.done = 1'b1;
      o.pcwrite = (op == 6'h04) ? z : ~z;
      push(1'($urandom), o);
    end else if (op == 6'h02) begin
      o.pcsrc = 2'b10; o.pcwrite = 1'b1; o.done = 1'b1; push(1'($urandom), o);
    end else if (op == 6'h20) begin
      o.pcsrc = 2'b11; o.pcwrite = 1'b1; o.done = 1'b1; push(1'($urandom), o);
    end else begin
      o.pcsrc = 2'b10; o.pcwrite = 1'b1; o.regwrite = 1'b1; o.regdst = 2'b10;
      o.memtoreg = 2'b10; o.done = 1'b1; push(1'($urandom), o);
    end
  endtask

  task automatic check_int(string name, int got, int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic check_out(string name, out_t got, out_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %05h want %05h", name, got, want);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  // Runs one directed instruction from FETCH and tallies strobe activity.
  task automatic run_vec(int idx, vec_t v);
    int n = 0, pcw = 0, rw = 0, mrd = 0, mwr = 0, ill = 0, ph = 0;
    logic done = 1'b0;
    bus.opcode = v.op; bus.funccode = v.fn; bus.zero = v.z;
    while (!done && n < 60) begin
      if (bus.memread || bus.memwrite) begin
        bus.mem_ready = (ph == (bus.iord ? v.mw : v.fw));
        ph = bus.mem_ready ? 0 : ph + 1;
      end else begin
        bus.mem_ready = 1'($urandom);
        ph = 0;
      end
      @(negedge clk);
      n++;
      pcw += int'(bus.pcwrite);
      rw  += int'(bus.regwrite);
      mrd += int'(bus.memread);
      mwr += int'(bus.memwrite);
      ill += int'(bus.illegal);
      done = bus.instr_done;
      adv();
    end
    check_int($sformatf("vec%0d_cycles", idx), n, v.cyc);
    check_int($sformatf("vec%0d_pcwrite", idx), pcw, v.pcw);
    check_int($sformatf("vec%0d_regwrite", idx), rw, v.rw);
    check_int($sformatf("vec%0d_memread", idx), mrd, v.mrd);
    check_int($sformatf("vec%0d_memwrite", idx), mwr, v.mwr);
    check_int($sformatf("vec%0d_illegal", idx), ill, v.ill);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    out_t o;
    checks = 0;
    errors = 0;
    //            op     fn     z   fw mw cyc pcw rw mrd mwr ill
    vecs[0]  = '{6'h00, 6'h22, 1'b0, 0, 0, 4, 1, 1, 1, 0, 0};
    vecs[1]  = '{6'h23, 6'h00, 1'b0, 2, 2, 9, 1, 1, 6, 0, 0};
    vecs[2]  = '{6'h2b, 6'h00, 1'b0, 0, 1, 5, 1, 0, 1, 2, 0};
    vecs[3]  = '{6'h04, 6'h00, 1'b1, 0, 0, 3, 2, 0, 1, 0, 0};
    vecs[4]  = '{6'h05, 6'h00, 1'b1, 0, 0, 3, 1, 0, 1, 0, 0};
    vecs[5]  = '{6'h05, 6'h00, 1'b0, 0, 0, 3, 2, 0, 1, 0, 0};
    vecs[6]  = '{6'h04, 6'h00, 1'b0, 0, 0, 3, 1, 0, 1, 0, 0};
    vecs[7]  = '{6'h03, 6'h00, 1'b0, 0, 0, 3, 2, 1, 1, 0, 0};
    vecs[8]  = '{6'h02, 6'h00, 1'b0, 0, 0, 3, 2, 0, 1, 0, 0};
    vecs[9]  = '{6'h20, 6'h00, 1'b0, 0, 0, 3, 2, 0, 1, 0, 0};
    vecs[10] = '{6'h3f, 6'h00, 1'b0, 0, 0, 2, 1, 0, 1, 0, 1};
    vecs[11] = '{6'h08, 6'h00, 1'b0, 1, 0, 5, 1, 1, 2, 0, 0};
    vecs[12] = '{6'h0c, 6'h00, 1'b0, 0, 0, 4, 1, 1, 1, 0, 0};

    bus.opcode = 6'h00; bus.funccode = 6'h20; bus.zero = 1'b0; bus.mem_ready = 1'b1;
    rst = 1'b1;
    adv(); adv();
    check_out("reset_outputs", get_out(), '0);
    rst = 1'b0;
    @(negedge clk);
    check_out("idle_after_reset", get_out(), '0);
    adv();
    o = '0; o.memread = 1'b1;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    check_out("first_fetch", get_out(), o);
    adv();

    // Reset during a stalled data read drops the request.
    bus.opcode = 6'h23;
    bus.mem_ready = 1'b1; adv();
    adv();
    adv();
    bus.mem_ready = 1'b0;
    @(negedge clk);
    o = '0; o.iord = 1'b1; o.memread = 1'b1;
    check_out("mem_rd_stall", get_out(), o);
    rst = 1'b1;
    adv();
    check_out("reset_mid_read", get_out(), '0);
    rst = 1'b0;
    adv();
    o = '0; o.memread = 1'b1;
    @(negedge clk);
    check_out("fetch_after_reset", get_out(), o);
    adv();

    for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);

    for (int n = 0; n < 200; n++) begin
      logic [5:0] op, fn;
      logic       z;
      int         pick;
      pick = $urandom_range(0, 11);
      case (pick)
        0, 1: op = 6'h00;
        2:    op = 6'h08;
        3:    op = 6'h0c;
        4:    op = 6'h23;
        5:    op = 6'h2b;
        6:    op = 6'h04;
        7:    op = 6'h05;
        8:    op = 6'h02;
        9:    op = 6'h20;
        10:   op = 6'h03;
        default: begin
          do op = 6'($urandom); while (is_legal(op));
        end
      endcase
      pick = $urandom_range(0, 5);
      case (pick)
        0: fn = 6'h20;
        1: fn = 6'h24;
        2: fn = 6'h25;
        3: fn = 6'h22;
        4: fn = 6'h2a;
        default: fn = 6'($urandom);
      endcase
      z = 1'($urandom);
      model_instr(op, fn, z, $urandom_range(0, 2), $urandom_range(0, 2));
      bus.opcode = op; bus.funccode = fn; bus.zero = z;
      while (q.size() > 0) begin
        cyc_t c;
        c = q.pop_front();
        bus.mem_ready = c.mr;
        @(negedge clk);
        check_out($sformatf("rand_instr%0d_op%02h", n, op), get_out(), c.exp);
        adv();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
